// File: rtl/key_gesture_decoder.sv
// Classifies debounced key gestures into short press, long press and double click,
// emitting one registered single-cycle pulse per recognised gesture.
module key_gesture_decoder #(
    parameter int LONG_CNT = 50_000_000,
    parameter int GAP_CNT  = 25_000_000,
    parameter int CNT_W    = 26
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_level,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_busy
);

    typedef enum logic [2:0] {
        WAIT_REL,
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        unique case (state_q)
            WAIT_REL: begin
                if (!i_key_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (i_key_level) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (!i_key_level) begin
                    state_d = WAIT_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_GAP: begin
                // A press on the timeout edge wins: it becomes the second click.
                if (i_key_level) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESS2: begin
                if (!i_key_level) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d  = LONG_HOLD;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!i_key_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == PRESS1) || (state_d == WAIT_GAP) || (state_d == PRESS2);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= WAIT_REL;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_double = double_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Directed bench for key_gesture_decoder: a cycle-by-cycle vector table for the basic
// gestures plus hand-written sequences for timeout priority and reset corner cases.
module tb_key_gesture_decoder;

    localparam int LONG_CNT = 8;
    localparam int GAP_CNT  = 6;
    localparam int CNT_W    = 4;

    // Expected outputs packed as {short, long, double, busy}.
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] BUSY = 4'b0001;
    localparam logic [3:0] SHRT = 4'b1000;
    localparam logic [3:0] LNG  = 4'b0100;
    localparam logic [3:0] DBL  = 4'b0010;

    typedef struct packed {
        logic       key;
        logic [3:0] exp;
    } vec_t;

    logic i_clk;
    logic i_rst;
    logic i_key_level;
    logic o_short;
    logic o_long;
    logic o_double;
    logic o_busy;

    int   total;
    int   bad;
    vec_t vecs[$];

    key_gesture_decoder #(
        .LONG_CNT(LONG_CNT),
        .GAP_CNT (GAP_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_key_level(i_key_level),
        .o_short    (o_short),
        .o_long     (o_long),
        .o_double   (o_double),
        .o_busy     (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {o_short, o_long, o_double, o_busy};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {s,l,d,b}=%b expected %b", name, act, exp);
        end
    endtask

    // Drive key at the falling edge, let one rising edge act, sample 1 time unit later.
    task automatic step_check(input logic key, input logic [3:0] exp, input string name);
        @(negedge i_clk);
        i_key_level = key;
        @(posedge i_clk);
        #1;
        check(name, exp);
    endtask

    task automatic add(input int n, input logic key, input logic [3:0] exp);
        vec_t v;
        v.key = key;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        i_key_level = 1'b0;
        i_rst       = 1'b1;

        // Vector table: leaving reset, short press, long press, double click.
        add(1, 1'b0, NONE);               // WAIT_REL -> IDLE
        add(3, 1'b1, BUSY);               // short press, 3 pressed edges
        add(1, 1'b0, BUSY);               // release edge
        add(5, 1'b0, BUSY);               // gap edges 1..5
        add(1, 1'b0, SHRT);               // 6th edge after release
        add(2, 1'b0, NONE);
        add(8, 1'b1, BUSY);               // long press: entry edge + 7
        add(1, 1'b1, LNG);                // 8 edges after entry
        add(11, 1'b1, NONE);              // held to 20 pressed cycles
        add(3, 1'b0, NONE);               // release after long: no event
        add(3, 1'b1, BUSY);               // first click
        add(2, 1'b0, BUSY);               // short gap
        add(3, 1'b1, BUSY);               // second click
        add(1, 1'b0, DBL);                // second-release edge
        add(7, 1'b0, NONE);               // no trailing short

        #12;
        check("reset_state", NONE);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step_check(vecs[i].key, vecs[i].exp, $sformatf("vec%0d", i));

        // Press on the exact gap-timeout edge must become a double click.
        step_check(1'b1, BUSY, "t4_press");
        step_check(1'b0, BUSY, "t4_release");
        for (int i = 1; i <= 5; i++) step_check(1'b0, BUSY, $sformatf("t4_gap%0d", i));
        step_check(1'b1, BUSY, "t4_timeout_edge_press");
        step_check(1'b0, DBL, "t4_double");
        step_check(1'b0, NONE, "t4_after");
        step_check(1'b0, NONE, "t4_after2");

        // Key held through reset yields nothing until released and pressed again.
        @(negedge i_clk);
        i_key_level = 1'b1;
        i_rst       = 1'b1;
        #1;
        check("t5_in_reset", NONE);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) step_check(1'b1, NONE, $sformatf("t5_held%0d", i));
        step_check(1'b0, NONE, "t5_release");
        step_check(1'b1, BUSY, "t5_press0");
        step_check(1'b1, BUSY, "t5_press1");
        step_check(1'b0, BUSY, "t5_release_edge");
        for (int i = 1; i <= 5; i++) step_check(1'b0, BUSY, $sformatf("t5_gap%0d", i));
        step_check(1'b0, SHRT, "t5_short");
        step_check(1'b0, NONE, "t5_after");

        // Reset in the middle of PRESS1 (cnt=5) aborts the gesture at once.
        for (int i = 0; i < 6; i++) step_check(1'b1, BUSY, $sformatf("t6_press%0d", i));
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("t6_async_reset", NONE);
        i_key_level = 1'b0;
        @(posedge i_clk);
        #1;
        check("t6_reset_held", NONE);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 12; i++) step_check(1'b0, NONE, $sformatf("t6_idle%0d", i));
        step_check(1'b1, BUSY, "t6_new_press");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
